// File: rtl/psum_row_accum.sv
// psum_row_accum: accumulates the PE partial-sum stream over several passes
// into a row buffer, then drains the row through bias/shift/activation/
// saturation to a valid/ready output stream.
// Optional feature macro: PSUM_RELU_EN (ReLU + upper clamp instead of
// signed saturation).
//
// Output handshake: an element transfers on a rising edge where
// out_valid & out_ready are both high; while out_valid is high and out_ready
// is low, out_data/out_last hold and out_valid stays high.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module psum_row_accum #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ROW_LEN    = 26,
  parameter int PSUM_WIDTH = DATA_WIDTH * 2 + 2,
  parameter int ACC_WIDTH  = PSUM_WIDTH + 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [3:0]                   num_pass,
  input  logic [4:0]                   row_len,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic [3:0]                   shift,
  input  logic                         psum_valid,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] ROW_LEN_L = 5'(ROW_LEN);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH + 1)'(-(2 ** (DATA_WIDTH - 1)));

  state_t r_state;
  state_t w_next_state;

  logic [4:0]                   r_idx;
  logic [3:0]                   r_pass_cnt;
  logic [3:0]                   r_num_pass;
  logic [4:0]                   r_row_len;
  logic signed [DATA_WIDTH-1:0] r_bias;
  logic [3:0]                   r_shift;
  logic                         r_out_valid;
  logic [DATA_WIDTH-1:0]        r_out_data;
  logic                         r_out_last;
  logic                         r_done;
  logic signed [ACC_WIDTH-1:0]  r_buf [ROW_LEN];

  logic [4:0]                   w_row_len_eff;
  logic [3:0]                   w_num_pass_eff;
  logic                         w_hs;
  logic                         w_acc_wr;
  logic                         w_row_end;
  logic                         w_final_psum;
  logic                         w_load;
  logic                         w_last_hs;
  logic                         w_rd_last;
  logic signed [ACC_WIDTH-1:0]  w_psum_ext;
  logic signed [ACC_WIDTH-1:0]  w_rd;
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic signed [ACC_WIDTH:0]    w_v;
  logic [DATA_WIDTH-1:0]        w_act;

  // Out-of-range configuration falls back to the full row / a single pass.
  assign w_row_len_eff  = ((row_len == 5'd0) || (row_len > ROW_LEN_L)) ? ROW_LEN_L : row_len;
  assign w_num_pass_eff = (num_pass == 4'd0) ? 4'd1 : num_pass;

  assign w_hs       = r_out_valid & out_ready;
  assign w_psum_ext = {{(ACC_WIDTH - PSUM_WIDTH){psum_in[PSUM_WIDTH-1]}}, psum_in};
  assign w_rd_last  = (r_idx == r_row_len - 5'd1);

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_next_state = r_state;
    w_acc_wr     = 1'b0;
    w_row_end    = 1'b0;
    w_final_psum = 1'b0;
    w_load       = 1'b0;
    w_last_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (psum_valid) begin
          w_acc_wr     = 1'b1;
          w_row_end    = (r_idx == r_row_len - 5'd1);
          w_final_psum = w_row_end && (r_pass_cnt == r_num_pass - 4'd1);
          if (w_final_psum) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Load on the first DRAIN cycle (register empty) and on every
        // handshake that is not the final one.
        w_load    = !r_out_valid || (w_hs && !r_out_last);
        w_last_hs = w_hs && r_out_last;
        if (w_last_hs) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Element value: shift, add bias one bit wider than the accumulator.
  always_comb begin
    w_rd      = r_buf[r_idx];
    w_shifted = w_rd >>> r_shift;
    w_v       = {w_shifted[ACC_WIDTH-1], w_shifted}
              + {{(ACC_WIDTH + 1 - DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias};
`ifdef PSUM_RELU_EN
    if (w_v < 0)            w_act = '0;
    else if (w_v > SAT_MAX) w_act = SAT_MAX[DATA_WIDTH-1:0];
    else                    w_act = w_v[DATA_WIDTH-1:0];
`else
    if (w_v < SAT_MIN)      w_act = SAT_MIN[DATA_WIDTH-1:0];
    else if (w_v > SAT_MAX) w_act = SAT_MAX[DATA_WIDTH-1:0];
    else                    w_act = w_v[DATA_WIDTH-1:0];
`endif
  end

  // State register, counters, latched configuration and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_pass_cnt  <= '0;
      r_num_pass  <= 4'd1;
      r_row_len   <= ROW_LEN_L;
      r_bias      <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last_hs;
      if ((r_state == ST_IDLE) && start) begin
        r_num_pass <= w_num_pass_eff;
        r_row_len  <= w_row_len_eff;
        r_bias     <= bias;
        r_shift    <= shift;
        r_idx      <= '0;
        r_pass_cnt <= '0;
      end
      if (w_acc_wr) begin
        if (w_row_end) begin
          r_idx      <= '0;
          r_pass_cnt <= w_final_psum ? 4'd0 : r_pass_cnt + 4'd1;
        end else begin
          r_idx <= r_idx + 5'd1;
        end
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_act;
        r_out_last  <= w_rd_last;
        r_idx       <= w_rd_last ? 5'd0 : r_idx + 5'd1;
      end else if (w_last_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_idx       <= '0;
      end
    end
  end

  // Row buffer: pass 0 overwrites, later passes accumulate; never cleared.
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      if (r_pass_cnt == 4'd0) r_buf[r_idx] <= w_psum_ext;
      else                    r_buf[r_idx] <= r_buf[r_idx] + w_psum_ext;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_psum_row_accum.sv
// tb_psum_row_accum: directed scenarios for psum_row_accum with a queue
// scoreboard; a negedge monitor pops expected {last,data} on each handshake.

module tb_psum_row_accum;

  localparam int DW = 8;
  localparam int PW = DW * 2 + 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    num_pass;
  logic [4:0]    row_len;
  logic [DW-1:0] bias;
  logic [3:0]    shift;
  logic          psum_valid;
  logic [PW-1:0] psum_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  psum_row_accum #(.DATA_WIDTH(DW), .ROW_LEN(26)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_pass   (num_pass),
    .row_len    (row_len),
    .bias       (bias),
    .shift      (shift),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q[$];
  int checks;
  int errors;
  int done_total;
  int done_snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic          stall_pend;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [DW:0]   e;
    stall_pend = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_total++;
      if (!rst) begin
        if (stall_pend) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(stall_data));
          check("hold_last", 32'(out_last), 32'(stall_last));
        end
        if (out_valid && out_ready) begin
          stall_pend = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got data 0x%0h last %0d, expected no output", out_data, out_last);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", 32'(out_data), 32'(e[DW-1:0]));
            check("sb_last", 32'(out_last), 32'(e[DW]));
          end
        end else if (out_valid) begin
          stall_pend = 1'b1;
          stall_data = out_data;
          stall_last = out_last;
        end else begin
          stall_pend = 1'b0;
        end
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int np, input int rl, input int b, input int sh);
    start    = 1'b1;
    num_pass = 4'(np);
    row_len  = 5'(rl);
    bias     = DW'(b);
    shift    = 4'(sh);
    tick();
    start = 1'b0;
    done_snap = done_total;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic send_psum(input int v);
    psum_valid = 1'b1;
    psum_in    = PW'(v);
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic send_row(input int a, input int b, input int c, input int d);
    send_psum(a);
    send_psum(b);
    send_psum(c);
    send_psum(d);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(busy), 32'd0);
    tick();
    check({name, "_done_once"}, 32'(done_total - done_snap), 32'd1);
    check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid_low"}, 32'(out_valid), 32'd0);
    exp_q.delete();
  endtask

  task automatic push_basic();
    push_exp(8'd35, 1'b0);
    push_exp(8'd65, 1'b0);
    push_exp(8'd95, 1'b0);
    push_exp(8'd125, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    done_total = 0;
    done_snap  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    num_pass   = '0;
    row_len    = '0;
    bias       = '0;
    shift      = '0;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // 1. basic accumulation with output latency check
    do_start(3, 4, 5, 0);
    push_basic();
    send_row(10, 20, 30, 40);
    send_row(10, 20, 30, 40);
    send_row(10, 20, 30, 40);
    check("lat_state_drain", 32'(dbg_state), 32'd2);
    check("lat_valid_edge1", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid_edge2", 32'(out_valid), 32'd1);
    check("lat_data_edge2", 32'(out_data), 32'd35);
    wait_done("basic");

    // 2a. saturation: 300 + 5 clamps to 127
    do_start(3, 4, 5, 0);
    push_exp(8'd127, 1'b0);
    push_exp(8'd127, 1'b0);
    push_exp(8'd127, 1'b0);
    push_exp(8'd127, 1'b1);
    repeat (3) send_row(100, 100, 100, 100);
    wait_done("sat");

    // 2b. shift: 300 >>> 2 = 75, + 5 = 80
    do_start(3, 4, 5, 2);
    push_exp(8'd80, 1'b0);
    push_exp(8'd80, 1'b0);
    push_exp(8'd80, 1'b0);
    push_exp(8'd80, 1'b1);
    repeat (3) send_row(100, 100, 100, 100);
    wait_done("shift");

    // 3a. activation: -50,-400,7,122 with bias 5
    do_start(1, 4, 5, 0);
`ifdef PSUM_RELU_EN
    push_exp(8'h00, 1'b0);
    push_exp(8'h00, 1'b0);
`else
    push_exp(8'hD3, 1'b0);
    push_exp(8'h80, 1'b0);
`endif
    push_exp(8'd12, 1'b0);
    push_exp(8'd127, 1'b1);
    send_row(-50, -400, 7, 122);
    wait_done("act");

    // 3b. single element row, num_pass 0 treated as 1, exact lower bound
    do_start(0, 1, 5, 0);
`ifdef PSUM_RELU_EN
    push_exp(8'h00, 1'b1);
`else
    push_exp(8'h80, 1'b1);
`endif
    send_psum(-133);
    wait_done("len1");

    // 3c. arithmetic shift of negatives, bias 0, shift 1
    do_start(1, 4, 0, 1);
`ifdef PSUM_RELU_EN
    push_exp(8'h00, 1'b0);
    push_exp(8'd4, 1'b0);
    push_exp(8'd127, 1'b0);
    push_exp(8'h00, 1'b1);
`else
    push_exp(8'hFC, 1'b0);
    push_exp(8'd4, 1'b0);
    push_exp(8'd127, 1'b0);
    push_exp(8'h80, 1'b1);
`endif
    send_row(-7, 9, 256, -300);
    wait_done("neg_shift");

    // 3d. row_len 0 and 31 both fall back to 26 elements
    for (int rl = 0; rl < 2; rl++) begin
      do_start(1, (rl == 0) ? 0 : 31, 0, 0);
      for (int k = 0; k < 26; k++) begin
`ifdef PSUM_RELU_EN
        push_exp((k < 10) ? 8'd0 : 8'(k - 10), (k == 25));
`else
        push_exp(8'(k - 10), (k == 25));
`endif
      end
      for (int k = 0; k < 26; k++) send_psum(k - 10);
      wait_done("full_row");
    end

    // 4. backpressure pattern 0,0,1,0,1,1,1 from the first valid cycle
    out_ready = 1'b0;
    do_start(3, 4, 5, 0);
    push_basic();
    repeat (3) send_row(10, 20, 30, 40);
    tick();
    begin
      logic [6:0] pat;
      pat = 7'b1110100;
      for (int i = 0; i < 7; i++) begin
        out_ready = pat[i];
        tick();
      end
    end
    out_ready = 1'b1;
    wait_done("bp");

    // 5. gaps, dropped psums in IDLE / start cycle / DRAIN, start during ACCUM
    psum_valid = 1'b1;
    psum_in    = PW'(77);
    tick();
    tick();
    psum_in = PW'(999);
    do_start(3, 4, 5, 0);
    psum_valid = 1'b0;
    push_basic();
    send_psum(10);
    send_psum(20);
    psum_in = PW'(555);
    repeat (3) tick();
    send_psum(30);
    send_psum(40);
    send_row(10, 20, 30, 40);
    start    = 1'b1;
    num_pass = 4'd1;
    bias     = 8'd100;
    tick();
    start    = 1'b0;
    num_pass = 4'd3;
    bias     = 8'd5;
    send_row(10, 20, 30, 40);
    psum_valid = 1'b1;
    psum_in    = PW'(999);
    repeat (4) tick();
    psum_valid = 1'b0;
    wait_done("ignored");

    // 6. reset mid-ACCUM, then a fresh single-pass row
    do_start(3, 4, 5, 0);
    send_row(10, 20, 30, 40);
    send_psum(50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    do_start(1, 4, 0, 0);
    push_exp(8'd1, 1'b0);
    push_exp(8'd2, 1'b0);
    push_exp(8'd3, 1'b0);
    push_exp(8'd4, 1'b1);
    send_row(1, 2, 3, 4);
    wait_done("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_row_accum.md
# psum_row_accum

Downstream stage of the convolution PE. Collects the PE's per-cycle partial-sum stream over several PE passes (kernel rows / input channels) into a row buffer. On completion it adds bias, rescales, applies activation and saturates to `DATA_WIDTH`. It then streams the finished output row to the feature-map writer with a valid/ready handshake.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): output/bias element width.
- `ROW_LEN`, default 26: maximum row length and buffer depth.
- `PSUM_WIDTH`, default `DATA_WIDTH*2+2`: PE partial-sum width, signed.
- `ACC_WIDTH`, default `PSUM_WIDTH+4`: accumulator width; cannot overflow for up to 15 passes.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches configuration and arms accumulation. Ignored unless IDLE.
- `num_pass`  in  4  passes to accumulate; 0 is treated as 1.
- `row_len`  in  5  elements per pass; 0 or >`ROW_LEN` is treated as `ROW_LEN`.
- `bias`  in  `DATA_WIDTH`  signed bias.
- `shift`  in  4  arithmetic right shift applied to the accumulator.
- `psum_valid`  in  1  partial sum valid (driven by PE `flag_comp`).
- `psum_in`  in  `PSUM_WIDTH`  signed partial sum.
- `out_valid`  out  1  output element valid.
- `out_ready`  in  1  consumer accepts on `out_valid & out_ready`.
- `out_data`  out  `DATA_WIDTH`  activated, saturated element.
- `out_last`  out  1  marks element `row_len-1`.
- `busy`  out  1  high in ACCUM and DRAIN.
- `done`  out  1  one-cycle pulse after the last element is accepted.

## Operation
- States:
  - IDLE → ACCUM on `start`.
  - ACCUM → DRAIN when the final psum of the final pass is sampled.
  - DRAIN → IDLE on the handshake of the last element.
- ACCUM:
  - Each sampled `psum_valid` cycle writes `buf[idx]`.
  - Pass 0 overwrites: `buf[idx] = sext(psum_in)`. Later passes add: `buf[idx] += sext(psum_in)`.
  - `idx` wraps from `row_len-1` to 0 and increments `pass_cnt`.
  - Cycles without `psum_valid` hold all state. There is no timeout.
- DRAIN element value: `v = (buf[idx] >>> shift) + sext(bias)`, computed at `ACC_WIDTH+1` bits, then activation/saturation (see Configuration).
- `psum_valid` in IDLE or DRAIN is dropped; no state changes.
- `start` in ACCUM or DRAIN is ignored.
- Buffer contents are never cleared; the pass-0 overwrite makes stale data irrelevant.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`, `done=0`; state IDLE, `idx=0`, `pass_cnt=0`.
- `busy` rises on the edge after the `start` cycle.
  - The first psum can be sampled the cycle after `start` (ACCUM).
  - `psum_valid` in the `start` cycle itself is dropped.
- Full throughput of one psum per cycle; no input backpressure.
- `out_valid` and the first element appear on the second rising edge after the edge that sampled the final psum: one edge to enter DRAIN, one to load the output register.
- The output register is reloaded on the same edge as each handshake: one element per cycle while `out_ready=1`.
- With `out_ready=0`, `out_data` and `out_last` hold stable and `out_valid` stays high.
- On the last handshake edge: `out_valid→0`, `busy→0`, `done=1` for exactly one cycle, state IDLE.
  - A `start` in the cycle `done` is high is accepted.
- `rst` mid-operation: next edge returns to reset values. In-flight data is discarded and `done` is not pulsed.

## Configuration
- `PSUM_RELU_EN` defined: negative `v` outputs 0; `v > 2^(DATA_WIDTH-1)-1` clamps to `2^(DATA_WIDTH-1)-1`.
- `PSUM_RELU_EN` undefined: signed saturation to [`-2^(DATA_WIDTH-1)`, `2^(DATA_WIDTH-1)-1`]; no ReLU.

## Test plan
Configuration for all scenarios unless stated: `DATA_WIDTH=8`, `row_len=4`, `out_ready=1`.
1. Basic: `num_pass=3`, `bias=5`, `shift=0`, each pass psums 10,20,30,40 → out 35,65,95,125; `out_last` on 125; `done` pulses once; first `out_valid` 2 edges after final psum.
2. Saturation/shift:
   - psums 100 ×3 passes, `bias=5`, `shift=0` → 127 on every element.
   - Same with `shift=2`: 300>>>2=75 → +5 → 80.
3. Activation: one pass, psum −50, `bias=5`, `shift=0` → 0 with `PSUM_RELU_EN`, −45 (0xD3) without; psum −400 without macro → −128.
4. Backpressure: scenario 1 with `out_ready` toggled 0,0,1,0,1,1,1 → each element held stable while stalled; sequence 35,65,95,125 unchanged; no duplicates or drops.
5. Gaps and ignored inputs: `psum_valid` deasserted for 3 cycles mid-pass and asserted in IDLE/DRAIN; `start` pulsed during ACCUM → results identical to scenario 1.
6. Reset mid-ACCUM after 5 psums, then fresh `start` with `num_pass=1`, psums 1,2,3,4, `bias=0` → out 1,2,3,4; no stale accumulation.
